// File: rtl/digit_scan_display_pkg.sv
// Shared types and active-low seven-segment codes ({g,f,e,d,c,b,a}) for the
// digit scan display.
package digit_scan_display_pkg;

   typedef logic [3:0] digit_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t SEG_0 = 7'b1000000;
   localparam seg_t SEG_1 = 7'b1111001;
   localparam seg_t SEG_2 = 7'b0100100;
   localparam seg_t SEG_3 = 7'b0110000;
   localparam seg_t SEG_4 = 7'b0011001;
   localparam seg_t SEG_5 = 7'b0010010;
   localparam seg_t SEG_6 = 7'b0000010;
   localparam seg_t SEG_7 = 7'b1111000;
   localparam seg_t SEG_8 = 7'b0000000;
   localparam seg_t SEG_9 = 7'b0010000;
   localparam seg_t SEG_A = 7'b0001000;
   localparam seg_t SEG_B = 7'b0000011;
   localparam seg_t SEG_C = 7'b1000110;
   localparam seg_t SEG_D = 7'b0100001;
   localparam seg_t SEG_E = 7'b0000110;
   localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/digit_scan_display_hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
   import digit_scan_display_pkg::*;
(
   input  digit_t digit,
   output seg_t   seg
);

   always_comb begin
      // NOTE: a default before the case keeps this purely combinational;
      // any path that skipped an assignment would otherwise infer a latch.
      seg = SEG_BLANK;
      case (digit)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/digit_scan_display.sv
// Buffers the last NUM_DIGITS strobed digits, scans them onto a common-anode
// seven-segment display and flags when the buffer equals PATTERN.
module digit_scan_display
   import digit_scan_display_pkg::*;
#(
   parameter int unsigned               NUM_DIGITS = 6,
   parameter int unsigned               SCAN_DIV   = 4,
   parameter logic [NUM_DIGITS*4-1:0]   PATTERN    = 24'h921212
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            digit_in,
   input  logic                  digit_valid,
   input  logic                  clear,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  match
);

   localparam int unsigned FC_W = $clog2(NUM_DIGITS + 1);
   localparam int unsigned SI_W = $clog2(NUM_DIGITS);
   localparam int unsigned PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [FC_W-1:0]       FILL_FULL = FC_W'(NUM_DIGITS);
   localparam logic [SI_W-1:0]       SI_LAST   = SI_W'(NUM_DIGITS - 1);
   localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(SCAN_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   digit_t                  digit_buf_q [NUM_DIGITS];
   digit_t                  digit_buf_d [NUM_DIGITS];
   logic [FC_W-1:0]         fill_cnt_q, fill_cnt_d;
   logic                    match_q, match_d;
   logic [NUM_DIGITS*4-1:0] packed_d;

   logic [SI_W-1:0]         scan_idx_q, scan_idx_d;
   logic [PS_W-1:0]         prescale_q, prescale_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   seg_t                    seg_q, seg_d;

   digit_t                  scan_digit;
   seg_t                    scan_seg;

   // Capture path: clear has priority and drops a coincident digit.
   always_comb begin
      digit_buf_d = digit_buf_q;
      fill_cnt_d  = fill_cnt_q;
      match_d     = match_q;
      packed_d    = '0;
      if (clear) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_buf_d[i] = '0;
         fill_cnt_d = '0;
         match_d    = 1'b0;
      end else if (digit_valid) begin
         digit_buf_d[0] = digit_in;
         for (int i = 1; i < NUM_DIGITS; i++) digit_buf_d[i] = digit_buf_q[i-1];
         if (fill_cnt_q != FILL_FULL) fill_cnt_d = fill_cnt_q + FC_W'(1);
         // Oldest digit lands in the most significant nibble.
         for (int i = 0; i < NUM_DIGITS; i++) packed_d[i*4 +: 4] = digit_buf_d[i];
         match_d = (fill_cnt_d == FILL_FULL) && (packed_d == PATTERN);
      end
   end

   // Scan path: free-running, independent of capture and clear.
   always_comb begin
      prescale_d = prescale_q + PS_W'(1);
      scan_idx_d = scan_idx_q;
      if (prescale_q == PS_LAST) begin
         prescale_d = '0;
         scan_idx_d = (scan_idx_q == SI_LAST) ? '0 : scan_idx_q + SI_W'(1);
      end
      scan_digit = digit_buf_q[scan_idx_q];
      an_d       = ~(AN_ONE << scan_idx_q);
      seg_d      = (32'(scan_idx_q) >= 32'(fill_cnt_q)) ? SEG_BLANK : scan_seg;
   end

   hex_to_7seg u_hex_to_7seg (
      .digit (scan_digit),
      .seg   (scan_seg)
   );

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the digit buffer is tiny and must read as empty after reset, so
         // it is reset like the rest of the state rather than left undefined.
         for (int i = 0; i < NUM_DIGITS; i++) digit_buf_q[i] <= '0;
         fill_cnt_q <= '0;
         match_q    <= 1'b0;
         scan_idx_q <= '0;
         prescale_q <= '0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_buf_q[i] <= digit_buf_d[i];
         fill_cnt_q <= fill_cnt_d;
         match_q    <= match_d;
         scan_idx_q <= scan_idx_d;
         prescale_q <= prescale_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign match = match_q;

endmodule
